handshake_sync_rx: RTL

Destination-side endpoint of a four-phase request/acknowledge CDC handshake. Synchronises an asynchronous request into the local clock domain and captures a multi-bit data bus that the source holds stable. Emits a one-cycle enable pulse to the local consumer and returns an acknowledge toward the source domain. Sits in the CDC/power group next to the reset synchroniser, and carries configuration and data words between the system and UART clock domains.

---
 rtl/handshake_sync_rx.sv | 85 ++++++++
 1 files changed

// File: rtl/handshake_sync_rx.sv
// Receive side of a four-phase req/ack CDC handshake. The request is synchronised
// into CLK, and the held-stable source bus is captured when the consumer is ready.
module handshake_sync_rx #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 UNSYNC_REQ,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 DEST_READY,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE,
  output logic                 ACK,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, CAPTURED, WAIT_REQ_LOW} state_e;

  state_e               state_q, state_d;
  logic [NUM_STAGES-1:0] sync_q;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 pulse_q, pulse_d;
  logic                 ack_q, ack_d;
  logic                 req_s;

  // Only the request crosses through the synchroniser. The bus is held stable
  // by the protocol, so it is sampled directly on the capture edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= {sync_q[NUM_STAGES-2:0], UNSYNC_REQ};
  end

  assign req_s = sync_q[NUM_STAGES-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      bus_q   <= '0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    pulse_d = 1'b0;
    ack_d   = ack_q;
    unique case (state_q)
      IDLE: begin
        ack_d = 1'b0;
        if (req_s && DEST_READY) begin
          bus_d   = UNSYNC_BUS;
          pulse_d = 1'b1;
          ack_d   = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        ack_d   = 1'b1;
        state_d = WAIT_REQ_LOW;
      end
      WAIT_REQ_LOW: begin
        ack_d = req_s;
        if (!req_s) state_d = IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign SYNC_BUS     = bus_q;
  assign ENABLE_PULSE = pulse_q;
  assign ACK          = ack_q;
  assign BUSY         = (state_q != IDLE);

endmodule
